ir_prefetch_unit: RTL and testbench

Parametrised instruction fetch front end that supersedes the single-shot fetch path. It keeps a program counter and issues pipelined word reads to instruction memory through a req/gnt/rvalid handshake. Returned words are buffered in a DEPTH-entry prefetch queue that feeds control with a valid/ready instruction stream. It adds redirect (branch) support with discard of in-flight responses, and a fetch-enable gate.

---
 rtl/ir_prefetch_unit_pkg.sv | 19 +
 rtl/ir_prefetch_fifo.sv | 63 ++++++
 rtl/ir_prefetch_unit.sv | 102 ++++++++++
 tb/tb_ir_prefetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding
// and width helpers for the occupancy and pointer counters.
package ir_prefetch_unit_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ir_prefetch_fifo.sv
// DEPTH-entry FIFO holding {instruction, pc} pairs; clear empties it in one cycle.
module ir_prefetch_fifo
    import ir_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic [W-1:0]            wdata,
    input  logic                    pop,
    output logic [W-1:0]            rdata,
    output logic [lvl_w(DEPTH)-1:0] count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push at full is only legal when the head leaves in the same cycle.
        do_push  = push && ((count_q != LW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ir_prefetch_unit.sv
// Instruction fetch front end: pipelined req/gnt/rvalid reads into a prefetch
// queue, with redirect that flushes the queue and discards in-flight responses.
module ir_prefetch_unit
    import ir_prefetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_fetch_en,
    input  logic                     i_redirect_en,
    input  logic [ADDR_W-1:0]        i_redirect_addr,
    output logic                     o_mem_req,
    output logic [ADDR_W-1:0]        o_mem_addr,
    input  logic                     i_mem_gnt,
    input  logic                     i_mem_rvalid,
    input  logic [INSTR_W-1:0]       i_mem_rdata,
    output logic                     o_ir_valid,
    output logic [INSTR_W-1:0]       o_ir,
    output logic [ADDR_W-1:0]        o_ir_pc,
    input  logic                     i_ir_ready,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int              LW      = lvl_w(DEPTH);
    localparam logic [LW:0]     DEPTH_V = (LW + 1)'(DEPTH);

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           pc_q, pc_d;
    logic [ADDR_W-1:0]           rsp_pc_q, rsp_pc_d;
    logic [LW-1:0]               outst_q, outst_d;
    logic [LW-1:0]               drop_q, drop_d;
    logic [LW-1:0]               count;
    logic [INSTR_W+ADDR_W-1:0]   head;
    logic                        credit_ok, issue, rsp, keep_rsp, ir_pop;

    assign o_ir_valid = (count != '0);
    assign o_ir       = o_ir_valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : '0;
    assign o_ir_pc    = o_ir_valid ? head[ADDR_W-1:0] : '0;
    assign o_mem_addr = pc_q;
    assign o_level    = count;

    always_comb begin
        // Queued plus in-flight words may never exceed the queue size.
        credit_ok = ({1'b0, count} + {1'b0, outst_q}) < DEPTH_V;
        o_mem_req = (state_q == ST_RUN) && i_fetch_en && credit_ok && !i_redirect_en;
        issue     = o_mem_req && i_mem_gnt;
        rsp       = i_mem_rvalid && (outst_q != '0);
        keep_rsp  = rsp && (drop_q == '0) && !i_redirect_en;
        ir_pop    = o_ir_valid && i_ir_ready;
        outst_d   = outst_q + LW'(issue) - LW'(rsp);
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        drop_d    = drop_q;
        state_d   = state_q;
        if (i_redirect_en) begin
            // Everything still in flight after this cycle belongs to the old stream.
            pc_d     = i_redirect_addr;
            rsp_pc_d = i_redirect_addr;
            drop_d   = outst_d;
            state_d  = (outst_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (issue)    pc_d     = pc_q + ADDR_W'(1);
            if (keep_rsp) rsp_pc_d = rsp_pc_q + ADDR_W'(1);
            if (rsp && (drop_q != '0)) drop_d = drop_q - LW'(1);
            if ((state_q == ST_DRAIN) && (drop_q == '0)) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    ir_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .clr   (i_redirect_en),
        .push  (keep_rsp),
        .wdata ({i_mem_rdata, rsp_pc_q}),
        .pop   (ir_pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_ir_prefetch_unit.sv
// Directed bench for ir_prefetch_unit: a table of per-cycle vectors plus
// hand-written redirect, wrap and mid-burst reset sequences.
module tb_ir_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic        req;
    logic [15:0] mem_addr;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic [2:0]  level;

    always #5 clk = ~clk;

    ir_prefetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_fetch_en      (fetch_en),
        .i_redirect_en   (redirect_en),
        .i_redirect_addr (redirect_addr),
        .o_mem_req       (req),
        .o_mem_addr      (mem_addr),
        .i_mem_gnt       (gnt),
        .i_mem_rvalid    (rvalid),
        .i_mem_rdata     (rdata),
        .o_ir_valid      (ir_valid),
        .o_ir            (ir),
        .o_ir_pc         (ir_pc),
        .i_ir_ready      (ready),
        .o_level         (level)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        logic        fe;
        logic        rd;
        logic        req;
        logic [15:0] addr;
        logic        v;
        logic [15:0] pc;
        logic [2:0]  lvl;
    } vec_t;

    rsp_t        mq[$];
    vec_t        vt[18];
    int          lat = 1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        s_req, s_valid;
    logic [15:0] s_addr, s_irpc;
    logic [31:0] s_ir;
    logic [2:0]  s_level;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: present the due memory response, sample outputs, record grants.
    task automatic tick();
        rsp_t r;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r      = mq.pop_front();
            rvalid = 1'b1;
            rdata  = {16'h0, r.addr} + 32'h100;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #1;
        s_req   = req;
        s_addr  = mem_addr;
        s_valid = ir_valid;
        s_ir    = ir;
        s_irpc  = ir_pc;
        s_level = level;
        if (req && gnt) begin
            r.addr = mem_addr;
            r.due  = cyc + lat;
            mq.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_en = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        fetch_en    = 1'b0;
        ready       = 1'b0;
        redirect_en = 1'b0;
        rvalid      = 1'b0;
        rdata       = '0;
        #2 rst_n = 1'b1;
        #1;
        chk({nm, "_req"},   {31'h0, req},      32'h0);
        chk({nm, "_addr"},  {16'h0, mem_addr}, 32'h0);
        chk({nm, "_valid"}, {31'h0, ir_valid}, 32'h0);
        chk({nm, "_ir"},    ir,                32'h0);
        chk({nm, "_irpc"},  {16'h0, ir_pc},    32'h0);
        chk({nm, "_level"}, {29'h0, level},    32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        cyc = 0;
    endtask

    // Free-running fetch with ready high; popped words must follow start, start+1, ...
    task automatic run_stream(input logic [15:0] start, input int ncyc, input int min_seen,
                              input string nm);
        logic [15:0] exp_pc;
        int          seen;
        exp_pc   = start;
        seen     = 0;
        fetch_en = 1'b1;
        ready    = 1'b1;
        repeat (ncyc) begin
            tick();
            if (s_valid) begin
                chk($sformatf("%s_pc%0d", nm, seen), {16'h0, s_irpc}, {16'h0, exp_pc});
                chk($sformatf("%s_ir%0d", nm, seen), s_ir, {16'h0, exp_pc} + 32'h100);
                exp_pc = exp_pc + 16'd1;
                seen++;
            end
        end
        tests++;
        if (seen < min_seen) begin
            fails++;
            $display("FAIL %s_count: got %0d instructions expected at least %0d", nm, seen, min_seen);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b1, 16'd0,  1'b0, 16'd0, 3'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 16'd1,  1'b0, 16'd0, 3'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 16'd2,  1'b1, 16'd0, 3'd1};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 16'd3,  1'b1, 16'd1, 3'd1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 16'd4,  1'b1, 16'd2, 3'd1};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 16'd5,  1'b1, 16'd2, 3'd2};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 16'd6,  1'b1, 16'd2, 3'd3};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 16'd6,  1'b1, 16'd2, 3'd4};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 16'd6,  1'b1, 16'd2, 3'd4};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 16'd6,  1'b1, 16'd2, 3'd4};
        vt[10] = '{1'b1, 1'b0, 1'b1, 16'd6,  1'b1, 16'd3, 3'd3};
        vt[11] = '{1'b1, 1'b0, 1'b0, 16'd7,  1'b1, 16'd3, 3'd3};
        vt[12] = '{1'b1, 1'b0, 1'b0, 16'd7,  1'b1, 16'd3, 3'd4};
        vt[13] = '{1'b1, 1'b1, 1'b0, 16'd7,  1'b1, 16'd3, 3'd4};
        vt[14] = '{1'b1, 1'b1, 1'b1, 16'd7,  1'b1, 16'd4, 3'd3};
        vt[15] = '{1'b1, 1'b1, 1'b1, 16'd8,  1'b1, 16'd5, 3'd2};
        vt[16] = '{1'b1, 1'b1, 1'b1, 16'd9,  1'b1, 16'd6, 3'd2};
        vt[17] = '{1'b1, 1'b1, 1'b1, 16'd10, 1'b1, 16'd7, 3'd2};

        do_reset("init");
        lat = 1;
        for (int i = 0; i < 18; i++) begin
            fetch_en = vt[i].fe;
            ready    = vt[i].rd;
            tick();
            chk($sformatf("vec%0d_req", i),   {31'h0, s_req},   {31'h0, vt[i].req});
            chk($sformatf("vec%0d_addr", i),  {16'h0, s_addr},  {16'h0, vt[i].addr});
            chk($sformatf("vec%0d_valid", i), {31'h0, s_valid}, {31'h0, vt[i].v});
            chk($sformatf("vec%0d_level", i), {29'h0, s_level}, {29'h0, vt[i].lvl});
            if (vt[i].v) begin
                chk($sformatf("vec%0d_irpc", i), {16'h0, s_irpc}, {16'h0, vt[i].pc});
                chk($sformatf("vec%0d_ir", i),   s_ir, {16'h0, vt[i].pc} + 32'h100);
            end
        end

        // Redirect with two responses in flight (3-cycle memory latency).
        do_reset("rst_redir");
        lat      = 3;
        fetch_en = 1'b1;
        ready    = 1'b1;
        tick();
        tick();
        redirect_en   = 1'b1;
        redirect_addr = 16'h0040;
        tick();
        chk("redir_req0", {31'h0, s_req}, 32'h0);
        tick();
        chk("redir_req1",   {31'h0, s_req},   32'h0);
        chk("redir_addr1",  {16'h0, s_addr},  32'h40);
        chk("redir_valid1", {31'h0, s_valid}, 32'h0);
        tick();
        chk("redir_req2",   {31'h0, s_req},   32'h0);
        chk("redir_valid2", {31'h0, s_valid}, 32'h0);
        run_stream(16'h0040, 20, 6, "redir");

        // Redirect landing on a cycle with a response arriving and a full pipe.
        do_reset("rst_same");
        lat      = 2;
        fetch_en = 1'b1;
        ready    = 1'b1;
        repeat (4) tick();
        redirect_en   = 1'b1;
        redirect_addr = 16'h0200;
        tick();
        chk("same_req0", {31'h0, s_req}, 32'h0);
        tick();
        chk("same_req1",   {31'h0, s_req},   32'h0);
        chk("same_valid1", {31'h0, s_valid}, 32'h0);
        chk("same_level1", {29'h0, s_level}, 32'h0);
        run_stream(16'h0200, 16, 6, "same");

        // PC wrap from 0xFFFF to 0x0000.
        do_reset("rst_wrap");
        lat           = 1;
        fetch_en      = 1'b1;
        ready         = 1'b1;
        redirect_en   = 1'b1;
        redirect_addr = 16'hFFFE;
        tick();
        chk("wrap_req0", {31'h0, s_req}, 32'h0);
        run_stream(16'hFFFE, 12, 6, "wrap");

        // Reset asserted mid-burst with three reads outstanding.
        do_reset("rst_mid0");
        lat      = 3;
        fetch_en = 1'b1;
        ready    = 1'b0;
        repeat (4) tick();
        chk("mid_busy_req", {31'h0, s_req}, 32'h1);
        do_reset("rst_mid");
        lat = 1;
        run_stream(16'h0000, 12, 6, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
